// File: rtl/vfs_pkg.sv
// vfs_pkg: shared types, constants and pixel packing for video_frame_store.
package vfs_pkg;
  typedef enum logic {W_WAIT, W_FILL} wr_state_t;
  localparam int STATS_W = 16;
  // Keeps the top ch bits of each RGB565 field; result is right-aligned in 15 bits.
  function automatic logic [14:0] pack_rgb565(input logic [15:0] d, input int ch);
    logic [4:0] r, g, b;
    r = d[15:11] >> (5 - ch);
    g = d[10:6] >> (5 - ch);
    b = d[4:0] >> (5 - ch);
    return (15'(r) << (2 * ch)) | (15'(g) << ch) | 15'(b);
  endfunction
endpackage

// File: rtl/vfs_dpram.sv
// vfs_dpram: simple dual-port RAM, one write port and one registered read port.
module vfs_dpram #(
  parameter int DEPTH = 131072,
  parameter int AW = 17,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/video_frame_store.sv
// video_frame_store: ping-pong frame store, camera writes back bank, reader sees front bank.
// Define VIDEO_FRAME_STORE_STATS_EN to add frames_done/frames_dropped/frames_aborted counters.
module video_frame_store import vfs_pkg::*; #(
  parameter int FRAME_PIXELS = 65536,
  parameter int ADDR_W = 16,
  parameter int CH_BITS = 3,
  localparam int PIX_W = 3 * CH_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cam_data,
  input  logic              cam_valid,
  input  logic              cam_sof,
  input  logic              rd_frame_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_pixel,
  output logic              rd_valid,
  output logic              front_sel,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] wr_addr
`ifdef VIDEO_FRAME_STORE_STATS_EN
  ,
  output logic [STATS_W-1:0] frames_done,
  output logic [STATS_W-1:0] frames_dropped,
  output logic [STATS_W-1:0] frames_aborted
`endif
);
  wr_state_t state;
  logic sof, start, wr_en, last, swap;
  logic [ADDR_W-1:0] waddr_eff;
  logic [PIX_W-1:0] pixel;
  assign pixel = PIX_W'(pack_rgb565(cam_data, CH_BITS));
  assign sof = cam_valid && cam_sof;
  assign start = sof && state == W_WAIT;
  assign wr_en = sof || (cam_valid && state == W_FILL);
  assign waddr_eff = sof ? '0 : wr_addr;
  assign last = wr_en && waddr_eff == ADDR_W'(FRAME_PIXELS - 1);
  assign swap = rd_frame_start && frame_ready;
  // A frame started in the swap cycle must land in the bank that becomes the back bank.
  vfs_dpram #(.DEPTH(2 * FRAME_PIXELS), .AW(ADDR_W + 1), .DW(PIX_W)) u_ram (
    .clk,
    .rst_n,
    .we(wr_en),
    .waddr({~(front_sel ^ swap), waddr_eff}),
    .wdata(pixel),
    .re(rd_en),
    .raddr({front_sel, rd_addr}),
    .rdata(rd_pixel)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= W_WAIT;
      wr_addr <= '0;
      front_sel <= 1'b0;
      frame_ready <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      front_sel <= front_sel ^ swap;
      frame_ready <= last ? 1'b1 : (swap || start) ? 1'b0 : frame_ready;
      if (wr_en) begin
        state <= last ? W_WAIT : W_FILL;
        wr_addr <= last ? '0 : waddr_eff + ADDR_W'(1);
      end
    end
`ifdef VIDEO_FRAME_STORE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frames_done <= '0;
      frames_dropped <= '0;
      frames_aborted <= '0;
    end else begin
      if (last) frames_done <= frames_done + STATS_W'(1);
      if (start && frame_ready && !swap && frames_dropped != '1) frames_dropped <= frames_dropped + STATS_W'(1);
      if (sof && state == W_FILL && frames_aborted != '1) frames_aborted <= frames_aborted + STATS_W'(1);
    end
`endif
endmodule

// File: tb/tb_video_frame_store.sv
// tb_video_frame_store: table-driven packing vectors plus scoreboarded read sequences.
module tb_video_frame_store;
  localparam int FP = 16, AW = 4, PW = 9;
  logic clk = 0, rst_n = 0;
  logic [15:0] cam_data = '0;
  logic cam_valid = 0, cam_sof = 0, rd_frame_start = 0, rd_en = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [PW-1:0] rd_pixel;
  logic rd_valid, front_sel, frame_ready;
  logic [AW-1:0] wr_addr;
`ifdef VIDEO_FRAME_STORE_STATS_EN
  logic [15:0] frames_done, frames_dropped, frames_aborted;
`endif
  int passed = 0, total = 0, ndone = 0, mpos = 0;
  logic ef = 0;
  logic [PW-1:0] sb [$];
  typedef struct { logic [15:0] d; logic [PW-1:0] p; } vec_t;
  vec_t v [7];

  video_frame_store #(.FRAME_PIXELS(FP), .ADDR_W(AW), .CH_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .cam_data(cam_data), .cam_valid(cam_valid), .cam_sof(cam_sof),
    .rd_frame_start(rd_frame_start), .rd_en(rd_en), .rd_addr(rd_addr), .rd_pixel(rd_pixel),
    .rd_valid(rd_valid), .front_sel(front_sel), .frame_ready(frame_ready), .wr_addr(wr_addr)
`ifdef VIDEO_FRAME_STORE_STATS_EN
    , .frames_done(frames_done), .frames_dropped(frames_dropped), .frames_aborted(frames_aborted)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] exp_pix(input logic [15:0] d);
    return {d[15:13], d[10:8], d[4:2]};
  endfunction

  function automatic logic [15:0] fd(input logic [15:0] seed, input int i);
    logic [3:0] k;
    k = 4'(i);
    return seed ^ {k[2:0], 2'b00, k[3:1], 3'b000, k[0], k[3], k[1], 2'b00};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic cyc(input logic cv, input logic cs, input logic rfs, input logic re,
                     input logic [15:0] d, input logic [AW-1:0] a);
    cam_valid = cv; cam_sof = cs; rd_frame_start = rfs; rd_en = re; cam_data = d; rd_addr = a;
    @(posedge clk); #1;
    cam_valid = 0; cam_sof = 0; rd_frame_start = 0; rd_en = 0;
    if (cv) begin
      mpos = cs ? 1 : mpos + 1;
      if (mpos == FP) begin mpos = 0; ndone++; end
    end
  endtask

  task automatic pix(input logic [15:0] d, input logic s); cyc(1, s, 0, 0, d, '0); endtask
  task automatic rd(input logic [AW-1:0] a, input logic [PW-1:0] e); sb.push_back(e); cyc(0, 0, 0, 1, '0, a); endtask
  task automatic swp(); cyc(0, 0, 1, 0, '0, '0); ef = ~ef; endtask
  task automatic frame(input logic [15:0] seed); for (int i = 0; i < FP; i++) pix(fd(seed, i), i == 0); endtask

  always @(negedge clk)
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL rd_valid: got 1 expected 0 (no read pending)");
      end else chk("rd_pixel", rd_pixel, sb.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{16'hFFFF, 9'h1FF}; v[1] = '{16'hE71C, 9'h1FF}; v[2] = '{16'h2104, 9'h049};
    v[3] = '{16'hF800, 9'h1C0}; v[4] = '{16'h07E0, 9'h038}; v[5] = '{16'h001F, 9'h007};
    v[6] = '{16'h0000, 9'h000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_front_sel", front_sel, 0); chk("rst_frame_ready", frame_ready, 0);
    chk("rst_wr_addr", wr_addr, 0); chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_pixel", rd_pixel, 0);
    rst_n = 1;
    for (int n = 0; n < 7; n++) begin
      for (int i = 0; i < FP; i++) pix(v[n].d, i == 0);
      chk("pack_frame_ready", frame_ready, 1);
      swp();
      chk("pack_front_sel", front_sel, ef); chk("pack_ready_clr", frame_ready, 0);
      rd(5, v[n].p);
    end
    for (int i = 0; i < FP; i++) begin
      pix(16'(i) << 11, i == 0);
      if (i == FP - 2) chk("ramp_ready_early", frame_ready, 0);
    end
    chk("ramp_ready", frame_ready, 1); chk("ramp_wr_addr", wr_addr, 0);
    swp();
    chk("ramp_front_sel", front_sel, ef); chk("ramp_ready_clr", frame_ready, 0);
    for (int i = 0; i < FP; i++) rd(AW'(i), exp_pix(16'(i) << 11));
    for (int i = 0; i < FP; i++) begin
      sb.push_back(exp_pix(16'(i) << 11));
      cyc(1, i == 0, 0, 1, fd(16'h5555, i), AW'(i));
    end
    chk("tear_ready", frame_ready, 1);
    rd(3, exp_pix(16'(3) << 11));
    swp();
    chk("tear_front_sel", front_sel, ef);
    rd(3, exp_pix(fd(16'h5555, 3)));
    for (int i = 0; i < 7; i++) pix(fd(16'hAAAA, i), i == 0);
    chk("abort_pre_wr_addr", wr_addr, 7);
    pix(fd(16'h1234, 0), 1);
    chk("abort_wr_addr", wr_addr, 1); chk("abort_ready", frame_ready, 0);
`ifdef VIDEO_FRAME_STORE_STATS_EN
    chk("frames_aborted", frames_aborted, 1);
`endif
    for (int i = 1; i < FP; i++) pix(fd(16'h1234, i), 0);
    chk("abort_done_ready", frame_ready, 1);
    swp();
    chk("abort_front_sel", front_sel, ef);
    for (int i = 0; i < FP; i++) rd(AW'(i), exp_pix(fd(16'h1234, i)));
    frame(16'h0F0F);
    chk("ovw_a_ready", frame_ready, 1);
    pix(fd(16'hF0F0, 0), 1);
    chk("ovw_ready_clr", frame_ready, 0);
`ifdef VIDEO_FRAME_STORE_STATS_EN
    chk("frames_dropped", frames_dropped, 1);
`endif
    for (int i = 1; i < FP - 1; i++) pix(fd(16'hF0F0, i), 0);
    cyc(1, 0, 1, 0, fd(16'hF0F0, FP - 1), '0);
    chk("ovw_last_ready", frame_ready, 1); chk("ovw_no_swap", front_sel, ef);
    swp();
    chk("ovw_swap", front_sel, ef); chk("ovw_swap_ready", frame_ready, 0);
    for (int i = 0; i < FP; i++) rd(AW'(i), exp_pix(fd(16'hF0F0, i)));
    frame(16'h3C3C);
    chk("sim_c_ready", frame_ready, 1);
    cyc(1, 1, 1, 0, fd(16'hC3C3, 0), '0);
    ef = ~ef;
    chk("sim_front_sel", front_sel, ef); chk("sim_ready", frame_ready, 0);
`ifdef VIDEO_FRAME_STORE_STATS_EN
    chk("sim_dropped", frames_dropped, 1);
`endif
    for (int i = 1; i < FP; i++) pix(fd(16'hC3C3, i), 0);
    chk("sim_d_ready", frame_ready, 1);
    for (int i = 0; i < FP; i++) rd(AW'(i), exp_pix(fd(16'h3C3C, i)));
    swp();
    chk("sim_swap", front_sel, ef);
    for (int i = 0; i < FP; i++) rd(AW'(i), exp_pix(fd(16'hC3C3, i)));
`ifdef VIDEO_FRAME_STORE_STATS_EN
    chk("frames_done", frames_done, 32'(ndone & 16'hFFFF));
`endif
    for (int i = 0; i < 4; i++) pix(fd(16'h7777, i), i == 0);
    sb.push_back(exp_pix(fd(16'hC3C3, 2)));
    cyc(1, 0, 0, 1, fd(16'h7777, 4), 2);
    chk("pre_rst_wr_addr", wr_addr, 5); chk("pre_rst_rd_valid", rd_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("arst_wr_addr", wr_addr, 0); chk("arst_front_sel", front_sel, 0);
    chk("arst_ready", frame_ready, 0); chk("arst_rd_valid", rd_valid, 0); chk("arst_rd_pixel", rd_pixel, 0);
`ifdef VIDEO_FRAME_STORE_STATS_EN
    chk("arst_done", frames_done, 0); chk("arst_dropped", frames_dropped, 0); chk("arst_aborted", frames_aborted, 0);
`endif
    mpos = 0; ndone = 0; ef = 0;
    @(posedge clk);
    #3;
    rst_n = 1;
    frame(16'h7777);
    chk("post_rst_ready", frame_ready, 1); chk("post_rst_wr_addr", wr_addr, 0);
`ifdef VIDEO_FRAME_STORE_STATS_EN
    chk("post_rst_done", frames_done, 32'(ndone));
`endif
    swp();
    chk("post_rst_front", front_sel, ef);
    rd(9, exp_pix(fd(16'h7777, 9)));
    cyc(0, 0, 0, 0, '0, '0);
    cyc(0, 0, 0, 0, '0, '0);
    chk("sb_drain", sb.size(), 0); chk("idle_rd_valid", rd_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/video_frame_store.md
# video_frame_store

Single-clock, double-buffered (ping-pong) frame store between the camera pixel stream and the projector/pixel read side. Truncates RGB565 camera words to 3*CH_BITS-bit pixels and writes a whole frame into the back buffer with an internal address counter. Publishes a completed frame by swapping buffers only at a reader frame boundary, so the reader never sees a torn frame.

## Interface
- FRAME_PIXELS, 65536: pixels per frame; buffer depth per bank.
- ADDR_W, 16: read/write address width; requires 2**ADDR_W >= FRAME_PIXELS.
- CH_BITS, 3: bits kept per colour channel, legal range 1..5; PIX_W = 3*CH_BITS.
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cam_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- cam_valid  in  1  cam_data valid this cycle; no backpressure.
- cam_sof  in  1  first pixel of a frame; only meaningful with cam_valid.
- rd_frame_start  in  1  one-cycle pulse: reader is about to begin a frame.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  pixel index within the front frame.
- rd_pixel  out  PIX_W  read data {R,G,B}.
- rd_valid  out  1  rd_pixel valid.
- front_sel  out  1  bank currently read; the writer uses the other bank.
- frame_ready  out  1  completed frame waiting in back bank.
- wr_addr  out  ADDR_W  next write index.

## Operation
- Packing: pixel = {cam_data[15 -: CH_BITS], cam_data[10 -: CH_BITS], cam_data[4 -: CH_BITS]}. For CH_BITS=3 this is {[15:13],[10:8],[4:2]}.
- Writer FSM, two states:
  - W_WAIT: ignores valid pixels without cam_sof. On cam_valid&&cam_sof, writes the pixel at index 0, sets wr_addr=1 and moves to W_FILL.
  - W_FILL: each cam_valid pixel writes at wr_addr, then wr_addr increments.
  - A write at FRAME_PIXELS-1 sets frame_ready, sets wr_addr=0 and returns to W_WAIT.
- Abort: cam_valid&&cam_sof in W_FILL with wr_addr!=0 restarts the frame. That pixel goes to index 0 and wr_addr becomes 1. The partial frame is discarded and frame_ready is unaffected.
- Overwrite: a frame start accepted in W_WAIT while frame_ready=1 clears frame_ready, because the back bank is being overwritten. The newest frame wins.
- Swap: rd_frame_start with registered frame_ready=1 toggles front_sel and clears frame_ready. With frame_ready=0, rd_frame_start has no effect.
- Physical write index = {~front_sel, wr_addr}. Physical read index = {front_sel, rd_addr}.
- rd_addr >= FRAME_PIXELS returns undefined data but still asserts rd_valid. No write can be corrupted by it.

## Timing
- Reset values: front_sel=0, frame_ready=0, wr_addr=0, rd_valid=0, rd_pixel=0, FSM=W_WAIT. Memory contents are not reset.
- Read latency is 1 cycle: rd_en at edge N gives rd_pixel and rd_valid at N+1. rd_valid is low whenever rd_en was low the previous cycle.
- Reads use front_sel as registered before the edge. A swap from rd_frame_start at edge N applies to reads issued at N+1 onward, so the reader pulses rd_frame_start one cycle before its first rd_en.
- Frame completion sets frame_ready at the edge of the last write. rd_frame_start in that same cycle sees the old value 0, so no swap happens then.
- Same-cycle frame start (in W_WAIT) and rd_frame_start with frame_ready=1: the swap wins and the frame_ready clear is suppressed. The new frame's writer targets the new back bank, and frame_ready ends at 0.
- Reset is asynchronous mid-frame: all state returns to reset values immediately, and the partial frame is lost.
- Write throughput: one pixel per cycle.

## Configuration
- VIDEO_FRAME_STORE_STATS_EN defined adds three outputs:
  - frames_done[15:0]: count of completed frames, wraps.
  - frames_dropped[15:0]: count of ready frames overwritten before a swap, saturates at 0xFFFF.
  - frames_aborted[15:0]: count of restarts in W_FILL, saturates.
  - All three reset to 0.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package vfs_pkg holds:
  - writer state encoding (W_WAIT, W_FILL);
  - a pack_rgb565 function parameterised by CH_BITS;
  - the stats counter width constant (16).
- One sub-module, vfs_dpram: simple dual-port RAM (one write port, one registered read port, same clock), depth 2*FRAME_PIXELS, width PIX_W, inferred to block RAM.
- The top holds the writer FSM, the swap logic and the stats counters.

## Test plan
- Bench configuration: FRAME_PIXELS=16, CH_BITS=3.
- Packing: write a full frame of cam_data=16'hFFFF, then swap and read index 5. Expect rd_pixel=9'h1FF. Write 16'hE71C and expect 9'h1FF. Write 16'h2104 and expect 9'h049.
- Full frame and swap:
  - Write 16 pixels with cam_data=i<<11. Expect frame_ready=1 after the 16th write.
  - Pulse rd_frame_start. Expect front_sel=1 and frame_ready=0 next cycle.
  - Read indices 0..15. Expect R field = i[4:2] with 1-cycle latency.
- No tear: while reading the front bank, stream a new frame of different data. Front reads stay unchanged until the next rd_frame_start after completion.
- Abort: cam_sof at wr_addr=7. Expect wr_addr=1 next cycle, frame_ready still 0, and frames_aborted=1 (stats build). Then complete 16 pixels and expect frame_ready=1.
- Overwrite and simultaneity:
  - Complete frame A without a swap, then start frame B. Expect frame_ready=0 and frames_dropped=1.
  - Complete B with rd_frame_start in the same cycle as the last write. Expect no swap; the next rd_frame_start swaps.
- Async reset: assert rst_n=0 mid-frame between clock edges. Expect wr_addr=0, front_sel=0, frame_ready=0 and rd_valid=0 immediately.
